cic_sync_prog: RTL and testbench
================================

// Module: cic_sync_prog
// PURPOSE
//  Programmable timing/sequencing generator for the PDM mic-array CIC decimator. Divides clk to pdm_clk
//  and samples PDM data at a programmable offset. Per PDM period, steps the integrators through the
//  active channels with an internal channel counter, gates the comb stage every decimation-th period,
//  and flags sequencing overruns.
//  Runtime-configurable successor to the fixed-ratio sync block; sits between the Wishbone config regs
//  and the cic integrator/comb datapath.
// PARAMETERS
//  CHANNELS   8   max mic channels; CH_W = $clog2(CHANNELS) (min 1)
//  DIV_W      8   width of pdm_ratio / read_time
//  DEC_W      16  width of decimation
// PORTS
//  clk                 in   1      system clock; single clock domain
//  resetn              in   1      reset, synchronous, active-high (despite name)
//  enable              in   1      run; 0 = hold counters at 0, outputs idle
//  pdm_ratio           in   DIV_W  PDM period - 1 in clk cycles (period = pdm_ratio+1)
//  read_time           in   DIV_W  sys_count value at which PDM data is sampled
//  decimation          in   DEC_W  comb every decimation+1 PDM periods
//  active_ch           in   CH_W   last active channel index (channels 0..active_ch)
//  overrun_clr         in   1      clears sticky overrun
//  pdm_clk             out  1      PDM clock to microphones
//  read_enable         out  1      1-cycle PDM sample strobe
//  integrator_enable   out  1      integrator update for channel_idx
//  comb_enable         out  1      comb update for channel_idx in this sequence
//  channel_idx         out  CH_W   channel currently processed
//  sample_strobe       out  1      1-cycle pulse: decimated sample set complete
//  overrun             out  1      sticky: trigger hit while sequence busy
//  busy                out  1      sequencer not in S_IDLE
// BEHAVIOUR
//  Reset (resetn=1 at posedge): all outputs 0, pdm_clk=0, sys_count=0, dec_count=0, state S_IDLE,
//  shadow cfg loaded from inputs.
//  Shadow cfg: pdm_ratio/read_time/decimation/active_ch sampled into shadow regs at reset, on enable
//  rising, and on each sys_count wrap. All internal logic uses only the shadow values, so mid-period
//  writes never glitch pdm_clk.
//  Divider: sys_count 0..ratio_s, wraps to 0. half = ratio_s>>1. pdm_clk registered:
//  0 while sys_count<=half, 1 otherwise. Required: ratio_s >= 1; ratio_s < 1 treated as 1.
//  Trigger: sys_count==read_s && enable (1 cycle). read_s > ratio_s: no trigger, nothing sampled.
//  FSM: S_IDLE -trigger-> S_READ (read_enable=1, 1 cyc) -> S_COMPUTE -> S_HOLD.
//   S_HOLD: channel_idx==ach_s -> S_IDLE; else channel_idx+1 -> S_COMPUTE.
//   integrator_enable=1 in S_COMPUTE and S_HOLD. channel_idx=0 on entry to S_READ.
//   Sequence length = 1 + 2*(ach_s+1) cycles. Outputs decoded registered from state (no comb paths).
//  Decimation: dec_count increments at each S_HOLD->S_IDLE exit; when dec_count==dec_s it resets to 0.
//   comb_enable = integrator_enable && (dec_count==dec_s).
//   sample_strobe = 1 cycle after that exit, when comb was active in the sequence.
//  Overrun: trigger while state!=S_IDLE -> trigger ignored, overrun<=1. Sticky until overrun_clr;
//   set wins over same-cycle clr.
//  enable falling: current sequence runs to S_IDLE, then sys_count held 0, pdm_clk=0, dec_count kept.
//  Reset mid-sequence: immediate return to reset values; no partial strobes.
//  Widths: dec_count DEC_W, sys_count DIV_W; compare exact, no saturation.
// STRUCTURE
//  Shared package cic_pkg.vh: state localparams (S_IDLE/S_READ/S_COMPUTE/S_HOLD) and default widths,
//  shared with cic datapath.
//  One sub-module: pdm_clk_div (sys_count, shadow ratio, pdm_clk, wrap and trigger pulses).
//  FSM, channel counter, decimation and overrun logic stay in the top module.
// TESTING
//  1 ratio=24, read=20, active_ch=7, dec=3 -> pdm_clk period 25 (13 low/12 high), read_enable at count 20,
//    16 integrator cycles, ch 0..7.
//  2 Same cfg, 8 periods -> comb_enable in periods 4,8 only; sample_strobe 2 pulses, 100 cycles apart.
//  3 ratio=10, active_ch=7 (seq 17 > period 11) -> overrun=1 at 2nd trigger; overrun_clr -> 0 next cycle.
//  4 Write ratio 24->49 mid-period -> current period stays 25 cycles, next is 50; no pdm_clk glitch.
//  5 resetn=1 during S_HOLD ch 3 -> next cycle all outputs 0, channel_idx=0, dec_count=0.
//  6 active_ch=0, read=30 > ratio=24 -> no read_enable ever; pdm_clk still toggles.

Source files
------------

// File: rtl/cic_sync_prog_pkg.sv
// cic_sync_prog_pkg
//   Shared definitions for the PDM CIC sequencing logic: sequencer state
//   encoding, default widths, and a helper to size the channel index.
//   Imported by cic_sync_prog and visible to the CIC datapath.
package cic_sync_prog_pkg;

    // Sequencer states. S_IDLE must stay at encoding 0 so that a cleared
    // state register means "idle".
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_COMPUTE = 2'd2,
        S_HOLD    = 2'd3
    } seq_state_e;

    localparam int DEF_CHANNELS = 8;
    localparam int DEF_DIV_W    = 8;
    localparam int DEF_DEC_W    = 16;

    // Channel index width: $clog2(n), never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cic_sync_prog_pdm_clk_div.sv
// pdm_clk_div
//   Programmable PDM clock divider with shadowed configuration.
//   sys_count runs 0..ratio_s and wraps; pdm_clk is low for the first half
//   of the period (sys_count <= ratio_s>>1) and high for the rest.
//   The shadow ratio/read offset are reloaded only while the divider is
//   stopped or on a wrap, so register writes take effect on a period
//   boundary and never shorten or stretch a pdm_clk phase.
// Ports
//   clk, resetn     clock, synchronous active-high reset
//   enable          run request
//   busy            sequencer still draining; keeps the divider running
//   pdm_ratio       period - 1 (live register value)
//   read_time       sample offset within the period (live register value)
//   pdm_clk         registered PDM clock
//   cfg_load        shadow registers reload at the coming edge
//   trigger         the coming edge enters the sample slot (sys_count ==
//                   read_s next cycle); lets the sequencer register its
//                   read strobe so it lines up with that count
module pdm_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             busy,
    input  logic [DIV_W-1:0] pdm_ratio,
    input  logic [DIV_W-1:0] read_time,
    output logic             pdm_clk,
    output logic             cfg_load,
    output logic             trigger
);

    logic [DIV_W-1:0] sys_count_q, sys_count_d;
    logic [DIV_W-1:0] ratio_s_q, ratio_s_d;
    logic [DIV_W-1:0] read_s_q, read_s_d;
    logic             pdm_clk_q, pdm_clk_d;
    logic [DIV_W-1:0] ratio_eff_q, ratio_eff_d;
    logic             run;
    logic             wrap;

    always_comb begin
        // A sequence already in flight is allowed to finish after enable drops.
        run = enable | busy;

        // A ratio of 0 would give a one-cycle period with no high phase.
        ratio_eff_q = (ratio_s_q == '0) ? DIV_W'(1) : ratio_s_q;
        wrap        = run && (sys_count_q == ratio_eff_q);
        cfg_load    = !run || wrap;

        ratio_s_d   = cfg_load ? pdm_ratio : ratio_s_q;
        read_s_d    = cfg_load ? read_time : read_s_q;
        ratio_eff_d = (ratio_s_d == '0) ? DIV_W'(1) : ratio_s_d;

        if (!run || wrap) begin
            sys_count_d = '0;
        end else begin
            sys_count_d = sys_count_q + 1'b1;
        end

        pdm_clk_d = (sys_count_d > (ratio_eff_d >> 1));
        // read_s beyond the period never matches, so nothing is sampled.
        trigger   = enable && (sys_count_d == read_s_d);
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            sys_count_q <= '0;
            pdm_clk_q   <= 1'b0;
            ratio_s_q   <= pdm_ratio;
            read_s_q    <= read_time;
        end else begin
            sys_count_q <= sys_count_d;
            pdm_clk_q   <= pdm_clk_d;
            ratio_s_q   <= ratio_s_d;
            read_s_q    <= read_s_d;
        end
    end

    assign pdm_clk = pdm_clk_q;

endmodule

// File: rtl/cic_sync_prog.sv
// cic_sync_prog
//   Timing/sequencing generator for the PDM mic-array CIC decimator.
//   Once per PDM period the sequencer issues a one-cycle read strobe, then
//   walks channels 0..active_ch with two integrator cycles each
//   (S_COMPUTE, S_HOLD). Every (decimation+1)-th sequence also enables the
//   comb stage and ends with a sample_strobe. A trigger arriving while a
//   sequence is still running is dropped and latches the sticky overrun.
// Ports
//   clk, resetn         clock, synchronous active-high reset
//   enable              run; low stops after the current sequence
//   pdm_ratio           PDM period - 1 in clk cycles
//   read_time           sys_count value at which PDM data is sampled
//   decimation          comb every decimation+1 PDM periods
//   active_ch           last active channel index
//   overrun_clr         clears overrun (a same-cycle set wins)
//   pdm_clk             PDM clock to the microphones
//   read_enable         one-cycle PDM sample strobe
//   integrator_enable   integrator update for channel_idx
//   comb_enable         comb update for channel_idx
//   channel_idx         channel being processed
//   sample_strobe       one-cycle pulse after a comb sequence completes
//   overrun             sticky sequencing overrun flag
//   busy                sequencer not idle
// All outputs are flops decoded from the next state; none are combinational.
module cic_sync_prog
    import cic_sync_prog_pkg::*;
#(
    parameter  int CHANNELS = DEF_CHANNELS,
    parameter  int DIV_W    = DEF_DIV_W,
    parameter  int DEC_W    = DEF_DEC_W,
    localparam int CH_W     = ch_width(CHANNELS)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [DIV_W-1:0] pdm_ratio,
    input  logic [DIV_W-1:0] read_time,
    input  logic [DEC_W-1:0] decimation,
    input  logic [CH_W-1:0]  active_ch,
    input  logic             overrun_clr,
    output logic             pdm_clk,
    output logic             read_enable,
    output logic             integrator_enable,
    output logic             comb_enable,
    output logic [CH_W-1:0]  channel_idx,
    output logic             sample_strobe,
    output logic             overrun,
    output logic             busy
);

    seq_state_e       state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [DEC_W-1:0] dec_count_q, dec_count_d;
    logic [DEC_W-1:0] dec_s_q, dec_s_d;
    logic [CH_W-1:0]  ach_s_q, ach_s_d;
    logic             read_enable_q, read_enable_d;
    logic             integ_q, integ_d;
    logic             comb_q, comb_d;
    logic             strobe_q, strobe_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;

    logic             cfg_load;
    logic             trigger;
    logic             seq_end;

    pdm_clk_div #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (enable),
        .busy     (busy_q),
        .pdm_ratio(pdm_ratio),
        .read_time(read_time),
        .pdm_clk  (pdm_clk),
        .cfg_load (cfg_load),
        .trigger  (trigger)
    );

    always_comb begin
        // Shadow config follows the divider's reload points.
        dec_s_d     = cfg_load ? decimation : dec_s_q;
        ach_s_d     = cfg_load ? active_ch : ach_s_q;

        state_d     = state_q;
        ch_d        = ch_q;
        dec_count_d = dec_count_q;
        seq_end     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d = S_READ;
                    ch_d    = '0;
                end
            end
            S_READ: begin
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (ch_q == ach_s_q) begin
                    state_d = S_IDLE;
                    ch_d    = '0;
                    seq_end = 1'b1;
                    // Exact compare: the count restarts only on equality.
                    if (dec_count_q == dec_s_q) begin
                        dec_count_d = '0;
                    end else begin
                        dec_count_d = dec_count_q + 1'b1;
                    end
                end else begin
                    state_d = S_COMPUTE;
                    ch_d    = ch_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ch_d    = '0;
            end
        endcase

        read_enable_d = (state_d == S_READ);
        integ_d       = (state_d == S_COMPUTE) || (state_d == S_HOLD);
        // dec_count only moves on the exit to S_IDLE, so within a sequence
        // this is stable for every channel.
        comb_d        = integ_d && (dec_count_d == dec_s_d);
        strobe_d      = seq_end && (dec_count_q == dec_s_q);
        busy_d        = (state_d != S_IDLE);

        // A trigger while busy is dropped; the set beats a same-cycle clear.
        if (trigger && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q       <= S_IDLE;
            ch_q          <= '0;
            dec_count_q   <= '0;
            dec_s_q       <= decimation;
            ach_s_q       <= active_ch;
            read_enable_q <= 1'b0;
            integ_q       <= 1'b0;
            comb_q        <= 1'b0;
            strobe_q      <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            dec_count_q   <= dec_count_d;
            dec_s_q       <= dec_s_d;
            ach_s_q       <= ach_s_d;
            read_enable_q <= read_enable_d;
            integ_q       <= integ_d;
            comb_q        <= comb_d;
            strobe_q      <= strobe_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
        end
    end

    assign read_enable       = read_enable_q;
    assign integrator_enable = integ_q;
    assign comb_enable       = comb_q;
    assign channel_idx       = ch_q;
    assign sample_strobe     = strobe_q;
    assign overrun           = overrun_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_cic_sync_prog.sv
// tb_cic_sync_prog
//   Bench for cic_sync_prog. Per-cycle outputs are compared with an
//   event-level model (period arithmetic plus a list of accepted sequence
//   start times); scenario totals are compared with hand-computed tables.
module tb_cic_sync_prog;

    localparam int CH_W = 3;
    localparam int VW   = 10;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            resetn;
    logic            enable;
    logic [7:0]      pdm_ratio;
    logic [7:0]      read_time;
    logic [15:0]     decimation;
    logic [CH_W-1:0] active_ch;
    logic            overrun_clr;
    logic            pdm_clk;
    logic            read_enable;
    logic            integrator_enable;
    logic            comb_enable;
    logic [CH_W-1:0] channel_idx;
    logic            sample_strobe;
    logic            overrun;
    logic            busy;

    always #5 clk = ~clk;

    cic_sync_prog #(
        .CHANNELS(8),
        .DIV_W   (8),
        .DEC_W   (16)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .enable           (enable),
        .pdm_ratio        (pdm_ratio),
        .read_time        (read_time),
        .decimation       (decimation),
        .active_ch        (active_ch),
        .overrun_clr      (overrun_clr),
        .pdm_clk          (pdm_clk),
        .read_enable      (read_enable),
        .integrator_enable(integrator_enable),
        .comb_enable      (comb_enable),
        .channel_idx      (channel_idx),
        .sample_strobe    (sample_strobe),
        .overrun          (overrun),
        .busy             (busy)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int j_cur    = 0;
    logic [VW-1:0] exp_q[$];

    int cnt_reads, cnt_integ, cnt_comb, cnt_strobes, cnt_rises, fin_ovr;
    int strobe_t0, strobe_t1;

    typedef struct {
        int ratio; int rd; int ach; int dec; int ncyc;
        int reads; int integ; int combs; int strobes; int ovr; int rises; int gap;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] out_vec();
        return {pdm_clk, read_enable, integrator_enable, comb_enable,
                channel_idx, sample_strobe, overrun, busy};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int t);
        while (j_cur < t) begin
            step();
            j_cur++;
        end
    endtask

    task automatic do_reset(input int r, input int rd, input int a, input int d);
        resetn      = 1'b1;
        enable      = 1'b0;
        overrun_clr = 1'b0;
        pdm_ratio   = 8'(r);
        read_time   = 8'(rd);
        active_ch   = CH_W'(a);
        decimation  = 16'(d);
        step();
        step();
        resetn = 1'b0;
        step();
    endtask

    // Step j counts edges since enable went high; sys_count = j mod period.
    // Sequences are tracked only by their start step and length.
    task automatic build_model(input int r, input int rd, input int a, input int d, input int n);
        int reff, p, len, next_ok, seq_n, j0, strobe_at, c, k, ch;
        bit active, comb_cur, ovr, pdm, re, ie, ce, ss, bz;
        reff = (r < 1) ? 1 : r;
        p = reff + 1;
        len = 1 + 2 * (a + 1);
        next_ok = 1; seq_n = 0; j0 = 0; strobe_at = -1;
        active = 0; comb_cur = 0; ovr = 0;
        exp_q.delete();
        for (int j = 1; j <= n; j++) begin
            c = j % p;
            pdm = (c > reff / 2);
            if (c == rd) begin
                if (j >= next_ok) begin
                    active    = 1;
                    j0        = j;
                    comb_cur  = ((seq_n % (d + 1)) == d);
                    seq_n++;
                    next_ok   = j + len + 1;
                    strobe_at = comb_cur ? j + len : -1;
                end else begin
                    ovr = 1;
                end
            end
            k = j - j0;
            re = 0; ie = 0; ce = 0; bz = 0; ch = 0;
            if (active && k < len) begin
                bz = 1;
                re = (k == 0);
                ie = (k >= 1);
                ch = ie ? (k - 1) / 2 : 0;
                ce = ie && comb_cur;
            end
            ss = (j == strobe_at);
            exp_q.push_back({pdm, re, ie, ce, CH_W'(ch), ss, ovr, bz});
        end
    endtask

    task automatic run_scenario(input int r, input int rd, input int a, input int d, input int n);
        logic [VW-1:0] v, e;
        logic prev_pdm;
        do_reset(r, rd, a, d);
        build_model(r, rd, a, d, n);
        cnt_reads = 0; cnt_integ = 0; cnt_comb = 0; cnt_strobes = 0; cnt_rises = 0;
        strobe_t0 = -1; strobe_t1 = -1;
        prev_pdm = 1'b0;
        enable = 1'b1;
        j_cur = 0;
        for (int j = 1; j <= n; j++) begin
            step();
            j_cur++;
            v = out_vec();
            e = exp_q.pop_front();
            check($sformatf("cycle r=%0d rd=%0d a=%0d d=%0d j=%0d", r, rd, a, d, j), 32'(v), 32'(e));
            cnt_reads += int'(read_enable);
            cnt_integ += int'(integrator_enable);
            cnt_comb  += int'(comb_enable);
            if (pdm_clk && !prev_pdm) cnt_rises++;
            prev_pdm = pdm_clk;
            if (sample_strobe) begin
                cnt_strobes++;
                if (strobe_t0 < 0) strobe_t0 = j;
                else if (strobe_t1 < 0) strobe_t1 = j;
            end
        end
        fin_ovr = int'(overrun);
        enable = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // ratio, rd, ach, dec, ncyc | reads, integ, combs, strobes, ovr, rises, gap
        tbl[0] = '{24, 20, 7, 3, 215,   8, 128, 32, 2, 0,  9, 100};
        tbl[1] = '{10,  5, 7, 0,  60,   3,  43, 43, 2, 1,  5,  22};
        tbl[2] = '{24, 30, 0, 0, 100,   0,   0,  0, 0, 0,  4,   0};
        tbl[3] = '{ 0,  1, 0, 1,  40,  10,  20, 10, 5, 1, 20,   8};
        tbl[4] = '{ 9,  0, 1, 2,  50,   5,  16,  4, 1, 0,  5,   0};

        // Reset state
        do_reset(24, 20, 7, 3);
        check("rst_pdm_clk", 32'(pdm_clk), 0);
        check("rst_read_enable", 32'(read_enable), 0);
        check("rst_integ", 32'(integrator_enable), 0);
        check("rst_comb", 32'(comb_enable), 0);
        check("rst_channel_idx", 32'(channel_idx), 0);
        check("rst_sample_strobe", 32'(sample_strobe), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);

        // Table-driven scenarios
        for (int i = 0; i < 5; i++) begin
            run_scenario(tbl[i].ratio, tbl[i].rd, tbl[i].ach, tbl[i].dec, tbl[i].ncyc);
            check($sformatf("tbl%0d_reads", i), 32'(cnt_reads), 32'(tbl[i].reads));
            check($sformatf("tbl%0d_integ", i), 32'(cnt_integ), 32'(tbl[i].integ));
            check($sformatf("tbl%0d_comb", i), 32'(cnt_comb), 32'(tbl[i].combs));
            check($sformatf("tbl%0d_strobes", i), 32'(cnt_strobes), 32'(tbl[i].strobes));
            check($sformatf("tbl%0d_overrun", i), 32'(fin_ovr), 32'(tbl[i].ovr));
            check($sformatf("tbl%0d_pdm_rises", i), 32'(cnt_rises), 32'(tbl[i].rises));
            if (tbl[i].gap != 0)
                check($sformatf("tbl%0d_strobe_gap", i), 32'(strobe_t1 - strobe_t0), 32'(tbl[i].gap));
        end

        // Randomized configurations against the model
        for (int i = 0; i < 6; i++) begin
            int r, rd, a, d;
            r  = int'($urandom_range(1, 30));
            rd = int'($urandom_range(0, r + 3));
            a  = int'($urandom_range(0, 7));
            d  = int'($urandom_range(0, 3));
            run_scenario(r, rd, a, d, 150);
        end

        // Overrun set, clear, and set-beats-clear
        do_reset(10, 5, 7, 0);
        enable = 1'b1;
        j_cur = 0;
        step_to(15);
        check("ovr_before_2nd_trigger", 32'(overrun), 0);
        step_to(16);
        check("ovr_set_2nd_trigger", 32'(overrun), 1);
        step_to(20);
        overrun_clr = 1'b1;
        step_to(21);
        check("ovr_cleared", 32'(overrun), 0);
        overrun_clr = 1'b0;
        step_to(37);
        overrun_clr = 1'b1;
        step_to(38);
        check("ovr_set_wins_over_clr", 32'(overrun), 1);
        step_to(39);
        check("ovr_cleared_again", 32'(overrun), 0);
        overrun_clr = 1'b0;
        enable = 1'b0;

        // Ratio write mid-period takes effect at the next period
        do_reset(24, 200, 0, 0);
        enable = 1'b1;
        j_cur = 0;
        step_to(10);
        pdm_ratio = 8'd49;
        step_to(12); check("ratio_old_low_end", 32'(pdm_clk), 0);
        step_to(13); check("ratio_old_high", 32'(pdm_clk), 1);
        step_to(24); check("ratio_old_last", 32'(pdm_clk), 1);
        step_to(25); check("ratio_new_start", 32'(pdm_clk), 0);
        step_to(49); check("ratio_new_low_end", 32'(pdm_clk), 0);
        step_to(50); check("ratio_new_high", 32'(pdm_clk), 1);
        step_to(74); check("ratio_new_last", 32'(pdm_clk), 1);
        step_to(75); check("ratio_new_wrap", 32'(pdm_clk), 0);
        enable = 1'b0;

        // Reset in the middle of a comb sequence, S_HOLD of channel 3
        do_reset(24, 20, 7, 1);
        enable = 1'b1;
        j_cur = 0;
        step_to(53);
        check("midrst_pre_integ", 32'(integrator_enable), 1);
        check("midrst_pre_ch", 32'(channel_idx), 3);
        check("midrst_pre_comb", 32'(comb_enable), 1);
        resetn = 1'b1;
        step();
        check("midrst_outputs_zero", 32'(out_vec()), 0);
        resetn = 1'b0;
        enable = 1'b0;
        step();
        enable = 1'b1;
        j_cur = 0;
        step_to(21);
        check("midrst_integ_after", 32'(integrator_enable), 1);
        check("midrst_dec_count_cleared", 32'(comb_enable), 0);
        step_to(40);
        check("midrst_no_strobe", 32'(sample_strobe), 0);
        enable = 1'b0;

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
